// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Define MDU_FAST_ZERO_EN when building mdu_seq to enable the zero-operand early exit.
`ifndef MDU_PKG_SV
`define MDU_PKG_SV

package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mduop_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mdu_state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // EX-stage request fields that steer an instruction to the sequencer.
    typedef struct packed {
        logic   mdu_en;
        mduop_t mdu_op;
    } ex_mdu_req_t;

    function automatic logic is_div(input mduop_t op);
        return op[2];
    endfunction

    function automatic logic a_signed(input mduop_t op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic b_signed(input mduop_t op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

`endif

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M sequencer: shift-add multiply and restoring divide on one 64-bit register.
// Optional build macro MDU_FAST_ZERO_EN short-circuits zero operands straight to DONE.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start_i,
    input  mduop_t          op_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] res_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    mdu_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    mduop_t            op_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opd_q;
    logic              neg_q;
    logic              neg_rem_q;
    logic [XLEN-1:0]   res_q;
    logic              done_q;

    // Operand preparation for a new request.
    logic            sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        special     = 1'b0;
        special_res = '0;
        sa          = a_signed(op_i) & opr_a_i[XLEN-1];
        sb          = b_signed(op_i) & opr_b_i[XLEN-1];
        abs_a       = sa ? -opr_a_i : opr_a_i;
        abs_b       = sb ? -opr_b_i : opr_b_i;
        if (is_div(op_i) && (opr_b_i == '0)) begin
            special     = 1'b1;
            special_res = op_i[1] ? opr_a_i : DIV_ZERO_Q;
        end else if (((op_i == MDU_DIV) || (op_i == MDU_REM)) &&
                     (opr_a_i == INT_MIN) && (opr_b_i == '1)) begin
            special     = 1'b1;
            special_res = op_i[1] ? '0 : INT_MIN;
        end
`ifdef MDU_FAST_ZERO_EN
        else if ((opr_a_i == '0) || (!is_div(op_i) && (opr_b_i == '0))) begin
            special     = 1'b1;
            special_res = '0;
        end
`endif
    end

    // One iteration: acc = {hi, lo}; multiply shifts right, divide shifts left.
    logic [XLEN:0]     add_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] acc_nxt;

    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opd_q};
        if (is_div(op_q)) begin
            if (!rem_diff[XLEN]) begin
                acc_nxt = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {add_sum, acc_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, res_calc;

    always_comb begin
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (op_q)
            MDU_MUL:                         res_calc = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: res_calc = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               res_calc = quo_fix;
            default:                         res_calc = rem_fix;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= MDU_MUL;
            acc_q     <= '0;
            opd_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            done_q    <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_q      <= op_i;
                        neg_q     <= sa ^ sb;
                        neg_rem_q <= sa;
                        cnt_q     <= CNT_W'(XLEN);
                        if (special) begin
                            res_q   <= special_res;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, is_div(op_i) ? abs_a : abs_b};
                            opd_q   <= is_div(op_i) ? abs_b : abs_a;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        res_q   <= res_calc;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_o = start_i & ~done_q & ~flush_i;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign res_o   = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table of M-ops plus flush, reset and operand-change sequences.
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int XLEN = 32;
`ifdef MDU_FAST_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic            clk = 1'b0;
    logic            arst_n;
    logic            start_i;
    mduop_t          op_i;
    logic [XLEN-1:0] opr_a_i;
    logic [XLEN-1:0] opr_b_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] res_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu_seq #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .start_i (start_i),
        .op_i    (op_i),
        .opr_a_i (opr_a_i),
        .opr_b_i (opr_b_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .res_o   (res_o)
    );

    typedef struct {
        mduop_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vec[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one op at a negedge (cycle 0), waits up to 40 cycles for done_o,
    // then checks that the following cycle is idle with start_i still held.
    task automatic run_op(input mduop_t op, input logic [31:0] a, input logic [31:0] b,
                          input int mut_cyc, input string tag,
                          output logic [31:0] res, output int lat, output int stall_cnt);
        lat       = -1;
        stall_cnt = 0;
        res       = '0;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        opr_a_i = a;
        opr_b_i = b;
        #1;
        if (stall_o) stall_cnt++;
        for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
            @(negedge clk);
            if (cyc == mut_cyc) begin
                op_i    = MDU_DIVU;
                opr_a_i = $urandom;
                opr_b_i = $urandom;
            end
            if (done_o) begin
                lat = cyc;
                res = res_o;
                check({tag, " stall low at done"}, {31'b0, stall_o}, 32'd0);
            end else if (stall_o) begin
                stall_cnt++;
            end
        end
        @(negedge clk);
        check({tag, " done single pulse"}, {31'b0, done_o}, 32'd0);
        check({tag, " start in DONE ignored"}, {31'b0, busy_o}, 32'd0);
        start_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [31:0] res_before;
        int          lat;
        int          sc;
        int          done_seen;

        vec[0]  = '{MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vec[1]  = '{MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vec[2]  = '{MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vec[3]  = '{MDU_DIV,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33};
        vec[4]  = '{MDU_REM,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33};
        vec[5]  = '{MDU_REMU,   32'd100,        32'd7,          32'd2,         33};
        vec[6]  = '{MDU_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, 1};
        vec[7]  = '{MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vec[8]  = '{MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vec[9]  = '{MDU_REM,    32'd5,          32'd0,          32'd5,         1};
        vec[10] = '{MDU_MULHSU, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 33};
        vec[11] = '{MDU_MULHSU, 32'd2,          32'hFFFF_FFFF, 32'd1,         33};
        vec[12] = '{MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vec[13] = '{MDU_DIVU,   32'hFFFF_FFFF, 32'd10,         32'h1999_9999, 33};
        vec[14] = '{MDU_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vec[15] = '{MDU_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vec[16] = '{MDU_MUL,    32'd0,          32'd9,          32'd0,         ZLAT};
        vec[17] = '{MDU_MULHU,  32'd5,          32'd0,          32'd0,         ZLAT};
        vec[18] = '{MDU_DIV,    32'd0,          32'd5,          32'd0,         ZLAT};
        vec[19] = '{MDU_DIV,    32'd0,          32'd0,          32'hFFFF_FFFF, 1};
        vec[20] = '{MDU_REM,    32'd0,          32'd0,          32'd0,         1};
        vec[21] = '{MDU_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vec[22] = '{MDU_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};

        arst_n  = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = MDU_MUL;
        opr_a_i = '0;
        opr_b_i = '0;
        #12;
        check("reset busy_o",  {31'b0, busy_o},  32'd0);
        check("reset done_o",  {31'b0, done_o},  32'd0);
        check("reset res_o",   res_o,            32'd0);
        check("reset stall_o", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < $size(vec); i++) begin
            run_op(vec[i].op, vec[i].a, vec[i].b, -1, $sformatf("v%0d", i), res, lat, sc);
            check($sformatf("v%0d %s result", i, vec[i].op.name()), res, vec[i].exp);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vec[i].lat));
            check($sformatf("v%0d stall cycles", i), 32'(sc), 32'(vec[i].lat));
        end

        // Operands and opcode change mid-CALC: latched MUL 6*7 must still complete.
        run_op(MDU_MUL, 32'd6, 32'd7, 3, "mut", res, lat, sc);
        check("mut result", res, 32'd42);
        check("mut latency", 32'(lat), 32'd33);

        // Flush and start together in IDLE: flush wins, nothing starts.
        @(negedge clk);
        start_i = 1'b1;
        flush_i = 1'b1;
        op_i    = MDU_DIVU;
        opr_a_i = 32'd9;
        opr_b_i = 32'd3;
        #1;
        check("idle flush stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        check("idle flush busy", {31'b0, busy_o}, 32'd0);
        start_i = 1'b0;
        flush_i = 1'b0;

        // DIV aborted by flush in cycle 10.
        res_before = res_o;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = MDU_DIV;
        opr_a_i = 32'd100;
        opr_b_i = 32'd7;
        for (int cyc = 1; cyc <= 10; cyc++) @(negedge clk);
        check("flush busy before", {31'b0, busy_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("flush stall low", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        check("flush idle cycle 11", {31'b0, busy_o}, 32'd0);
        flush_i   = 1'b0;
        start_i   = 1'b0;
        done_seen = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        check("flush no done", 32'(done_seen), 32'd0);
        check("flush res unchanged", res_o, res_before);

        run_op(MDU_MUL, 32'd3, 32'd4, -1, "post flush", res, lat, sc);
        check("post flush result", res, 32'd12);
        check("post flush latency", 32'(lat), 32'd33);

        // Asynchronous reset in cycle 5 of a MUL.
        @(negedge clk);
        start_i = 1'b1;
        op_i    = MDU_MUL;
        opr_a_i = 32'd5;
        opr_b_i = 32'd5;
        for (int cyc = 1; cyc <= 5; cyc++) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("mid reset busy_o", {31'b0, busy_o}, 32'd0);
        check("mid reset done_o", {31'b0, done_o}, 32'd0);
        check("mid reset res_o",  res_o,           32'd0);
        start_i = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;

        run_op(MDU_MULHU, 32'h0001_0000, 32'h0001_0000, -1, "post reset", res, lat, sc);
        check("post reset result", res, 32'd1);
        check("post reset latency", 32'(lat), 32'd33);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle RV32M multiply/divide sequencer attached to the EX stage, alongside the single-cycle ALU.
- Accepts one M-extension op from the EX stage input, iterates a shared shift-add / restoring-divide datapath, and stalls the pipeline until the result is ready.
- The EX stage muxes res_o into its result when done_o is high.

Parameters:
- XLEN, 32, operand/result width (only 32 supported in the RV32 core).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  core clock
- arst_n  in  1  asynchronous active-low reset
- start_i  in  1  EX holds a valid M-op (level; held until done_o)
- op_i  in  3  mduop_t (funct3): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- opr_a_i  in  XLEN  rs1 value
- opr_b_i  in  XLEN  rs2 value
- flush_i  in  1  pipeline flush (branch taken / trap); aborts the op
- stall_o  out  1  hold IF/ID/EX registers
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  res_o valid this cycle (single-cycle pulse)
- res_o  out  XLEN  result

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset values: state=IDLE, counter=0, all internal registers=0, res_o=0, done_o=0, busy_o=0.
- Combinational output: stall_o = start_i & ~done_o & ~flush_i.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start_i & ~flush_i: latch op_i, |opr_a_i|, |opr_b_i| (abs only for signed ops) and result sign; counter=XLEN; go to CALC.
  - Special cases below go straight to DONE instead.
- CALC, one iteration per cycle:
  - MUL*: 64-bit shift-add, multiplier LSB-first.
  - DIV*/REM*: restoring divide, 64-bit remainder:quotient shift register.
  - Counter decrements each cycle; at counter==1, register the sign-corrected result into res_o and go to DONE.
- DONE: done_o=1 for exactly one cycle; go to IDLE. A start_i seen in DONE belongs to the retiring instruction and is ignored.
- Latency: start cycle = 0; CALC occupies cycles 1..32; done_o asserts in cycle 33. stall_o is high in cycles 0..32.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32]. Sign: MULH = sa^sb; MULHSU = sa; MULHU = 0.
  - Negate the full 64-bit product before selecting the half.
- Quotient/remainder signs: quotient negated when sa^sb (signed ops); remainder takes the dividend sign.
- Special cases (IDLE -> DONE directly, done_o in cycle 1):
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = opr_a_i.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- flush_i in any state: go to IDLE next cycle; done_o forced 0; res_o unchanged. flush_i has priority over start_i.
- Reset mid-operation: immediate return to IDLE with all registers cleared.
- Opcode or operand changes while in CALC are ignored; the latched values are used.

Optional Feature:
- Macro: MDU_FAST_ZERO_EN.
- Defined: in IDLE, if opr_a_i==0, or (MUL* and opr_b_i==0), go directly to DONE with res_o=0 (done_o in cycle 1).
  - Divide-by-zero with a zero dividend still obeys the divide-by-zero rule: DIV = 0xFFFFFFFF, REM = 0.
- Undefined: zero operands take the full 33-cycle path; the result is identical.

Decomposition:
- mdu_pkg (mdu_pkg.svh, include-guarded), containing:
  - mduop_t enum (3-bit, funct3 encoding);
  - mdu_state_t enum {IDLE, CALC, DONE};
  - localparams DIV_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- The ex_stage input struct gains an mdu_en bit and carries mduop_t.
- No sub-module: the FSM and datapath stay in one module of roughly 200 lines.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3) -> stall_o high cycles 0..32; done_o pulse in cycle 33; res_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> res_o=0xFFFFFFFE. MULH with the same operands -> res_o=0x00000000.
- DIV -7 / 2 -> res_o=0xFFFFFFFD (-3). REM -7 / 2 -> res_o=0xFFFFFFFF (-1). REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> done_o in cycle 1, res_o=0xFFFFFFFF. REM 0x80000000 / 0xFFFFFFFF -> done_o in cycle 1, res_o=0.
- DIV started, flush_i asserted in cycle 10 -> IDLE in cycle 11; no done_o. A new MUL 3*4 issued next -> res_o=12 after 33 cycles.
- arst_n pulsed low in cycle 5 of a MUL -> busy_o, done_o and res_o are 0 immediately. With MDU_FAST_ZERO_EN defined, MUL 0*9 -> done_o in cycle 1, res_o=0.
